// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - MMU-facing 128x32 on-chip SRAM responder with wait states
//
// Purpose: serves single read/write requests from the MMU. A request starts on a
// rising edge of read_pulse or write_pulse. It completes after WAIT_CYCLES wait
// states, and completion is flagged by a one-cycle SRAM_ready.
//
// Ports:
//   soc_clk, soc_rst    clock; synchronous active-high reset
//   SRAM_addr_sel       word address (ADDR_W bits)
//   SRAM_byte_sel       byte-lane enables, bit i covers data bits [8i+7:8i]
//   SRAM_dat_in         write data
//   read_pulse          read request, rising-edge triggered
//   write_pulse         write request, rising-edge triggered
//   SRAM_dat_out        read data, holds until the next read completes
//   SRAM_ready          one-cycle completion strobe
//   SRAM_busy           high while an access is in flight
//   SRAM_err            one-cycle error strobe
//   parity_inject_n     (SRAM_RESP_PARITY_EN only) active-low; when low at write
//                       capture, the stored parity bits are inverted
//
// Optional feature macro: SRAM_RESP_PARITY_EN (per-lane even parity).
module sram_responder #(
  parameter int ADDR_W      = 7,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              soc_clk,
  input  logic              soc_rst,
  input  logic [ADDR_W-1:0] SRAM_addr_sel,
  input  logic [3:0]        SRAM_byte_sel,
  input  logic [31:0]       SRAM_dat_in,
  input  logic              read_pulse,
  input  logic              write_pulse,
`ifdef SRAM_RESP_PARITY_EN
  input  logic              parity_inject_n,
`endif
  output logic [31:0]       SRAM_dat_out,
  output logic              SRAM_ready,
  output logic              SRAM_busy,
  output logic              SRAM_err
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] LAST_CNT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              rd_hist;
  logic              wr_hist;
  logic              lat_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [3:0]        lat_be;
  logic [31:0]       lat_dat;
  logic [31:0]       mem [DEPTH];

  logic              rd_rise;
  logic              wr_rise;
  logic              start;
  logic              dual;

  assign rd_rise = read_pulse & ~rd_hist;
  assign wr_rise = write_pulse & ~wr_hist;
  assign start   = (state == IDLE) & (rd_rise ^ wr_rise);
  assign dual    = (state == IDLE) & rd_rise & wr_rise;

  // Access strobe and operands. With no wait states the access happens on the
  // capture edge itself, so the live inputs are used instead of the latches.
  logic              acc_go;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [3:0]        acc_be;
  logic [31:0]       acc_dat;
  logic [31:0]       acc_mask;
  logic [31:0]       rd_word;

  always_comb begin
    acc_go   = 1'b0;
    acc_wr   = lat_wr;
    acc_addr = lat_addr;
    acc_be   = lat_be;
    acc_dat  = lat_dat;
    if (WAIT_CYCLES == 0) begin
      acc_go   = start;
      acc_wr   = wr_rise;
      acc_addr = SRAM_addr_sel;
      acc_be   = SRAM_byte_sel;
      acc_dat  = SRAM_dat_in;
    end else begin
      acc_go   = (state == WAIT) && (cnt == LAST_CNT);
    end
    acc_mask = 32'd0;
    for (int i = 0; i < 4; i++) begin
      acc_mask[8*i +: 8] = {8{acc_be[i]}};
    end
  end

  assign rd_word = mem[acc_addr];

  // Array is never cleared; a write aborted by reset never reaches this edge.
  always_ff @(posedge soc_clk) begin
    if (!soc_rst && acc_go && acc_wr) begin
      mem[acc_addr] <= (mem[acc_addr] & ~acc_mask) | (acc_dat & acc_mask);
    end
  end

`ifdef SRAM_RESP_PARITY_EN
  logic       lat_inj_n;
  logic       acc_inj_n;
  logic [3:0] par_mem [DEPTH];
  logic [3:0] new_par;
  logic [3:0] par_bad;
  logic       perr_q;

  always_comb begin
    acc_inj_n = (WAIT_CYCLES == 0) ? parity_inject_n : lat_inj_n;
    new_par   = 4'd0;
    par_bad   = 4'd0;
    for (int i = 0; i < 4; i++) begin
      new_par[i] = (^acc_dat[8*i +: 8]) ^ ~acc_inj_n;
      par_bad[i] = (^rd_word[8*i +: 8]) ^ par_mem[acc_addr][i];
    end
  end

  always_ff @(posedge soc_clk) begin
    if (!soc_rst && acc_go && acc_wr) begin
      par_mem[acc_addr] <= (par_mem[acc_addr] & ~acc_be) | (new_par & acc_be);
    end
  end

  // Parity result is computed at the access edge and reported with SRAM_ready.
  always_ff @(posedge soc_clk) begin
    if (soc_rst) begin
      lat_inj_n <= 1'b1;
      perr_q    <= 1'b0;
    end else begin
      if (start) lat_inj_n <= parity_inject_n;
      if (acc_go) perr_q <= !acc_wr && |(par_bad & acc_be);
    end
  end
`endif

  always_ff @(posedge soc_clk) begin
    if (soc_rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      rd_hist      <= 1'b1;
      wr_hist      <= 1'b1;
      lat_wr       <= 1'b0;
      lat_addr     <= '0;
      lat_be       <= 4'd0;
      lat_dat      <= 32'd0;
      SRAM_dat_out <= 32'd0;
      SRAM_ready   <= 1'b0;
      SRAM_busy    <= 1'b0;
      SRAM_err     <= 1'b0;
    end else begin
      // History always tracks the pins, so a pulse held high never retriggers.
      rd_hist    <= read_pulse;
      wr_hist    <= write_pulse;
      SRAM_ready <= 1'b0;
      SRAM_err   <= 1'b0;
      if (acc_go && !acc_wr) begin
        SRAM_dat_out <= rd_word & acc_mask;
      end
      case (state)
        IDLE: begin
          if (dual) begin
            SRAM_ready <= 1'b1;
            SRAM_err   <= 1'b1;
          end else if (start) begin
            lat_wr    <= wr_rise;
            lat_addr  <= SRAM_addr_sel;
            lat_be    <= SRAM_byte_sel;
            lat_dat   <= SRAM_dat_in;
            cnt       <= 4'd0;
            SRAM_busy <= 1'b1;
            state     <= (WAIT_CYCLES > 0) ? WAIT : DONE;
          end
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) state <= DONE;
        end
        DONE: begin
          SRAM_ready <= 1'b1;
          SRAM_busy  <= 1'b0;
`ifdef SRAM_RESP_PARITY_EN
          SRAM_err   <= perr_q;
`endif
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - scoreboard bench for sram_responder
module tb_sram_responder;

  localparam int ADDR_W      = 7;
  localparam int WAIT_CYCLES = 2;

  logic              soc_clk = 1'b0;
  logic              soc_rst = 1'b1;
  logic [ADDR_W-1:0] SRAM_addr_sel = '0;
  logic [3:0]        SRAM_byte_sel = 4'd0;
  logic [31:0]       SRAM_dat_in = 32'd0;
  logic              read_pulse = 1'b0;
  logic              write_pulse = 1'b0;
`ifdef SRAM_RESP_PARITY_EN
  logic              parity_inject_n = 1'b1;
`endif
  logic [31:0]       SRAM_dat_out;
  logic              SRAM_ready;
  logic              SRAM_busy;
  logic              SRAM_err;

  sram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .soc_clk         (soc_clk),
    .soc_rst         (soc_rst),
    .SRAM_addr_sel   (SRAM_addr_sel),
    .SRAM_byte_sel   (SRAM_byte_sel),
    .SRAM_dat_in     (SRAM_dat_in),
    .read_pulse      (read_pulse),
    .write_pulse     (write_pulse),
`ifdef SRAM_RESP_PARITY_EN
    .parity_inject_n (parity_inject_n),
`endif
    .SRAM_dat_out    (SRAM_dat_out),
    .SRAM_ready      (SRAM_ready),
    .SRAM_busy       (SRAM_busy),
    .SRAM_err        (SRAM_err)
  );

  always #5 soc_clk = ~soc_clk;

  typedef struct {
    bit          is_rd;
    bit          err;
    logic [31:0] dat;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [1 << ADDR_W];
`ifdef SRAM_RESP_PARITY_EN
  logic [3:0]  bad [1 << ADDR_W];
`endif
  int          tests = 0;
  int          fails = 0;
  int          ready_cnt = 0;

  always @(negedge soc_clk) if (SRAM_ready === 1'b1) ready_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // One request: push the expectation, pulse, then wait (bounded) for SRAM_ready.
  task automatic req(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                     input logic [3:0] be, input logic [31:0] dat, input bit inj,
                     input bit intrude, input string tag);
    exp_t        e;
    int          lat;
    logic [31:0] m;
    m = lane_mask(be);
    @(negedge soc_clk);
    SRAM_addr_sel = addr;
    SRAM_byte_sel = be;
    SRAM_dat_in   = dat;
`ifdef SRAM_RESP_PARITY_EN
    parity_inject_n = ~inj;
`endif
    read_pulse  = rd;
    write_pulse = wr;
    e.is_rd = rd && !wr;
    e.err   = 1'b0;
    e.dat   = 32'd0;
    if (rd && wr) begin
      e.err = 1'b1;
    end else if (wr) begin
      model[addr] = (model[addr] & ~m) | (dat & m);
`ifdef SRAM_RESP_PARITY_EN
      bad[addr] = inj ? (bad[addr] | be) : (bad[addr] & ~be);
`endif
    end else begin
      e.dat = model[addr] & m;
`ifdef SRAM_RESP_PARITY_EN
      e.err = |(bad[addr] & be);
`endif
    end
    sbq.push_back(e);
    @(negedge soc_clk);
    lat = 1;
    read_pulse  = 1'b0;
    write_pulse = 1'b0;
    // Scramble inputs: the in-flight access must use only the captured values.
    SRAM_addr_sel = ~addr;
    SRAM_byte_sel = ~be;
    SRAM_dat_in   = ~dat;
`ifdef SRAM_RESP_PARITY_EN
    parity_inject_n = inj;
`endif
    if (!(rd && wr)) check({tag, " busy"}, {31'd0, SRAM_busy}, 32'd1);
    while (SRAM_ready !== 1'b1 && lat < 20) begin
      @(negedge soc_clk);
      lat++;
      if (intrude && lat == 2) begin
        SRAM_addr_sel = addr + 1'b1;
        SRAM_dat_in   = 32'hFFFF_FFFF;
        SRAM_byte_sel = 4'hF;
        write_pulse   = 1'b1;
      end
      if (intrude && lat == 3) write_pulse = 1'b0;
    end
    if (SRAM_ready !== 1'b1) begin
      check({tag, " ready timeout"}, 32'd0, 32'd1);
      void'(sbq.pop_front());
    end else begin
      e = sbq.pop_front();
      check({tag, " latency"}, 32'(lat - 1), (rd && wr) ? 32'd0 : 32'(WAIT_CYCLES + 1));
      check({tag, " err"}, {31'd0, SRAM_err}, {31'd0, e.err});
      if (e.is_rd) check({tag, " data"}, SRAM_dat_out, e.dat);
      if (!(rd && wr)) check({tag, " busy at ready"}, {31'd0, SRAM_busy}, 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " dat_out"}, SRAM_dat_out, 32'd0);
    check({tag, " ready"}, {31'd0, SRAM_ready}, 32'd0);
    check({tag, " busy"}, {31'd0, SRAM_busy}, 32'd0);
    check({tag, " err"}, {31'd0, SRAM_err}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rc;
    repeat (3) @(negedge soc_clk);
    check_reset_outputs("reset");
    soc_rst = 1'b0;

    req(0, 1, 7'h05, 4'hF, 32'hDEAD_BEEF, 0, 0, "wr05");
    req(1, 0, 7'h05, 4'hF, 32'h0, 0, 0, "rd05");

    req(0, 1, 7'h7F, 4'hF, 32'h1122_3344, 0, 0, "wr7f full");
    req(0, 1, 7'h7F, 4'b1010, 32'hAABB_CCDD, 0, 0, "wr7f lanes");
    req(1, 0, 7'h7F, 4'hF, 32'h0, 0, 0, "rd7f full");
    req(1, 0, 7'h7F, 4'b0001, 32'h0, 0, 0, "rd7f lane0");

    req(0, 1, 7'h10, 4'hF, 32'hCAFE_F00D, 0, 0, "wr10");
    req(1, 1, 7'h10, 4'hF, 32'h0, 0, 0, "dual10");
    req(1, 0, 7'h10, 4'hF, 32'h0, 0, 0, "rd10 after dual");

    req(0, 1, 7'h21, 4'hF, 32'h5A5A_5A5A, 0, 0, "wr21");
    #1 rc = ready_cnt;
    req(0, 1, 7'h20, 4'hF, 32'h0102_0304, 0, 1, "wr20 intruded");
    repeat (3) @(negedge soc_clk);
    #1 check("single ready", 32'(ready_cnt - rc), 32'd1);
    req(1, 0, 7'h20, 4'hF, 32'h0, 0, 0, "rd20");
    req(1, 0, 7'h21, 4'hF, 32'h0, 0, 0, "rd21");

    req(1, 0, 7'h05, 4'hF, 32'h0, 0, 0, "rd05 again");
    req(0, 1, 7'h06, 4'hF, 32'h7777_7777, 0, 0, "wr06");
    check("dat_out hold", SRAM_dat_out, 32'hDEAD_BEEF);
    req(0, 1, 7'h05, 4'h0, 32'hFFFF_FFFF, 0, 0, "wr05 no lanes");
    req(1, 0, 7'h05, 4'h0, 32'h0, 0, 0, "rd05 no lanes");
    req(1, 0, 7'h05, 4'hF, 32'h0, 0, 0, "rd05 unchanged");

    req(0, 1, 7'h03, 4'hF, 32'h0, 0, 0, "wr03 zero");
    #1 rc = ready_cnt;
    @(negedge soc_clk);
    SRAM_addr_sel = 7'h03;
    SRAM_byte_sel = 4'hF;
    SRAM_dat_in   = 32'h1234_5678;
    write_pulse   = 1'b1;
    @(negedge soc_clk);
    write_pulse = 1'b0;
    read_pulse  = 1'b1;
    soc_rst     = 1'b1;
    @(negedge soc_clk);
    check_reset_outputs("mid-access reset");
    soc_rst = 1'b0;
    repeat (4) @(negedge soc_clk);
    check("held pulse no busy", {31'd0, SRAM_busy}, 32'd0);
    read_pulse = 1'b0;
    #1 check("no ready after abort", 32'(ready_cnt - rc), 32'd0);
    req(1, 0, 7'h03, 4'hF, 32'h0, 0, 0, "rd03 after abort");

`ifdef SRAM_RESP_PARITY_EN
    req(0, 1, 7'h08, 4'hF, 32'h0000_00FF, 1, 0, "wr08 inject");
    req(1, 0, 7'h08, 4'hF, 32'h0, 0, 0, "rd08 parity");
    req(0, 1, 7'h09, 4'hF, 32'h0000_00FF, 0, 0, "wr09 clean");
    req(1, 0, 7'h09, 4'hF, 32'h0, 0, 0, "rd09 parity");
`endif

    check("scoreboard drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Responder end of the MMU-to-SRAM interface: 128 x 32-bit word-addressed on-chip SRAM with byte-lane enables.
- Accepts single read/write requests, signalled by rising edges on read_pulse / write_pulse.
- Each access completes after a configurable wait-state count; completion is flagged with a one-cycle SRAM_ready.
- Sits between tb_top wiring and the MMU; replaces the behavioural SRAM model.

Parameters:
- ADDR_W, 7, word address width; depth = 2**ADDR_W words.
- WAIT_CYCLES, 2, wait states between capture and completion; legal range 0..15.

Ports:
- soc_clk  in  1  system clock, all logic on rising edge
- soc_rst  in  1  synchronous reset, active-high
- SRAM_addr_sel  in  ADDR_W  word address
- SRAM_byte_sel  in  4  byte-lane enables; bit i = bits [8i+7:8i]
- SRAM_dat_in  in  32  write data
- read_pulse  in  1  read request; rising edge starts an access
- write_pulse  in  1  write request; rising edge starts an access
- SRAM_dat_out  out  32  read data
- SRAM_ready  out  1  one-cycle completion strobe
- SRAM_busy  out  1  high while an access is in flight
- SRAM_err  out  1  one-cycle error strobe

Behaviour:
- Reset values: SRAM_dat_out = 0, SRAM_ready = 0, SRAM_busy = 0, SRAM_err = 0, state = IDLE, wait counter = 0.
- Reset sets the read/write edge-detect history registers to 1. A pulse held high through reset is not a request; it must go low and then high again.
- Memory array is not cleared by reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE, on a detected rising edge (pulse = 1, history = 0):
  - latch address, byte_sel, dat_in and the op type;
  - clear the counter;
  - go to WAIT if WAIT_CYCLES > 0, otherwise to DONE;
  - SRAM_busy = 1 from the next cycle.
- WAIT: counter increments each cycle. When counter == WAIT_CYCLES-1, perform the access and go to DONE.
- Access is performed on the clock edge that enters DONE:
  - Write: update only the enabled byte lanes; other lanes keep their contents.
  - Read: SRAM_dat_out takes the enabled lanes; disabled lanes read as 0.
- DONE: SRAM_ready = 1 for exactly one cycle; SRAM_busy = 0 in this cycle; next state is IDLE.
- Latency: with the capture edge as edge 0, SRAM_ready is high in the cycle after edge WAIT_CYCLES+1. With WAIT_CYCLES = 0, SRAM_ready is high in the cycle after edge 1.
- SRAM_dat_out holds its value until the next read completes. Writes do not change it.
- byte_sel = 4'b0000: no array change; a read returns 0; SRAM_ready is still generated.
- Rising edges on both pulses in the same IDLE cycle:
  - no access, no capture;
  - SRAM_err = 1 and SRAM_ready = 1 on the next cycle, both for one cycle;
  - state stays IDLE.
- Rising edges during WAIT or DONE are ignored; no queueing. History registers still update every cycle, so a pulse held high does not retrigger later.
- Request inputs are sampled only at the capture edge; later changes do not affect the in-flight access.
- Reset mid-access: the transaction is aborted and outputs go to reset values. A write aborted before entering DONE leaves the array unchanged.
- Address wrap: none; every ADDR_W value is a valid word.

Optional Feature:
- Macro: SRAM_RESP_PARITY_EN
- Defined:
  - each byte lane stores an even-parity bit, written on write from the enabled lanes;
  - on read, any enabled lane with a parity mismatch sets SRAM_err = 1 in the same cycle as SRAM_ready;
  - data is still returned unmodified;
  - adds input port parity_inject_n (1 bit, active-low): when 0 during a write capture, stored parity bits are inverted, for test.
- Undefined:
  - no parity storage, no parity_inject_n port;
  - SRAM_err is driven only by the simultaneous-pulse case.

Test Plan:
- Write 0xDEADBEEF to address 0x05 with byte_sel 4'hF, then read 0x05 -> SRAM_dat_out = 0xDEADBEEF; SRAM_ready high 3 cycles after each capture edge (WAIT_CYCLES = 2).
- Preload 0x11223344 at 0x7F, write 0xAABBCCDD with byte_sel 4'b1010, read with byte_sel 4'hF -> 0xAA22CC44; read with byte_sel 4'b0001 -> 0x00000044.
- Rising edges on read_pulse and write_pulse in the same cycle at 0x10 -> SRAM_err and SRAM_ready high for one cycle; a later read of 0x10 returns its prior contents.
- Write pulse at 0x20 issued, second write pulse at 0x21 during WAIT -> only 0x20 is written; exactly one SRAM_ready; 0x21 unchanged.
- Assert soc_rst one cycle into WAIT of a write 0x12345678 to 0x03 (prior contents 0) -> all outputs return to reset values; a read of 0x03 returns 0.
- With SRAM_RESP_PARITY_EN: write 0x000000FF to 0x08 with parity_inject_n = 0, then read -> SRAM_dat_out = 0x000000FF with SRAM_err = 1 alongside SRAM_ready.
